i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
- Round-robin arbiter sharing one I2C byte master between N_REQ requesters.
- Latches the winning requester's address, rw and data, then launches exactly one master transaction.
- Tracks the master's `ready` through the transaction, returns read data and completion status to that requester, and guards against a hung bus with a timeout.
- Sits between the system-side requesters (sensor poller, config loader, and others) and the I2C master's `enable`/`addr`/`data_in`/`rw`/`ready`/`data_out` interface.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 4096, clk cycles allowed per transaction before abort is flagged (>=16).
- CNT_W, 13, width of timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, same clock that feeds the I2C master.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- req  in  N_REQ  per-requester request level.
- req_addr  in  7*N_REQ  7-bit slave address per requester; requester i uses bits [7i+6:7i].
- req_rw  in  N_REQ  1 = read, 0 = write.
- req_wdata  in  8*N_REQ  write byte per requester; requester i uses bits [8i+7:8i].
- gnt  out  N_REQ  one-hot grant, high for the whole owned transaction.
- done  out  N_REQ  one-cycle completion pulse to the owner.
- err  out  1  valid with `done`: 1 = timeout or master returned without completing.
- rdata  out  8  read byte; valid with `done` when rw = 1, held until the next `done`.
- m_enable  out  1  to master `enable`.
- m_addr  out  7  to master `addr`.
- m_rw  out  1  to master `rw`.
- m_wdata  out  8  to master `data_in`.
- m_ready  in  1  from master `ready`; high = master idle.
- m_rdata  in  8  from master `data_out`.

Behaviour:
- **Reset (rst = 0, asynchronous):**
  - State = IDLE.
  - gnt, done, err, m_enable, m_rw = 0.
  - m_addr = 0, m_wdata = 0, rdata = 0.
  - Priority pointer = 0, timeout counter = 0.
- **States:** IDLE, LAUNCH, BUSY, FINISH, DRAIN.
- **IDLE:**
  - Arbitrate only when m_ready = 1 and req != 0.
  - The winner is the first set req bit searching upward from the pointer, wrapping at N_REQ-1 -> 0.
  - Registered on the next edge:
    - gnt = onehot(winner).
    - m_addr, m_rw, m_wdata latched from the winner's slice.
    - m_enable = 1, counter cleared.
    - State -> LAUNCH.
  - Fields are sampled once; later changes on req_* are ignored for this transaction.
- **LAUNCH:**
  - m_enable is held at 1 until m_ready = 0 is seen.
  - Because the master samples `enable` on its divided clock, this takes 1..DIVIDE_BY+1 cycles.
  - On m_ready = 0: m_enable = 0 next cycle, state -> BUSY.
- **BUSY:**
  - Wait for m_ready = 1, then state -> FINISH.
  - rdata is captured from m_rdata on that same edge, only if m_rw = 1.
- **FINISH (one cycle):**
  - done[owner] = 1 and err = 0.
  - gnt cleared.
  - Pointer = owner+1, modulo N_REQ.
  - State -> IDLE.
  - Earliest new grant is the cycle after FINISH, so there is one idle cycle between transactions.
- **Timeout:**
  - The counter increments every cycle in LAUNCH and BUSY.
  - When it reaches TIMEOUT_CYC-1:
    - done[owner] = 1, err = 1 for one cycle.
    - gnt cleared, m_enable = 0, pointer advanced.
    - State -> DRAIN.
- **DRAIN:** hold until m_ready = 1, then -> IDLE. No grant is issued while in DRAIN.
- **Requester rules:**
  - A requester holds req high with its fields stable until it sees its `done`.
  - Dropping req after grant does not abort the transaction; `done` still pulses.
  - A requester may re-raise req the cycle after its `done`, but it gets lowest priority (round-robin).
- **Simultaneous requests:** resolved purely by pointer order; no starvation. Each requester waits at most N_REQ-1 transactions.
- **Master busy at start:** if m_ready = 0 in IDLE (e.g. master still in STOP), no grant is issued.
- **Mid-operation reset:** forces all outputs to reset values immediately. The master's own reset is independent.
- **Output guarantees:** `done` and `gnt` are never asserted for two requesters in the same cycle. m_addr, m_rw and m_wdata stay stable from grant until FINISH or timeout.

Test Plan:
- **Single write:**
  - Stimulus: req = 0001, addr 0x50, rw 0, wdata 0xA5.
  - Response: gnt = 0001, then m_enable = 1 until m_ready falls; m_addr = 0x50, m_wdata = 0xA5.
  - Finish: done[0] pulses once with err = 0 one cycle after m_ready returns high.
- **Single read:**
  - Stimulus: req[2] read from 0x68; the slave model returns 0x3C.
  - Response: done[2] with rdata = 0x3C, err = 0; rdata holds 0x3C afterwards.
- **Round-robin:**
  - Stimulus: req = 1111 held continuously.
  - Response: grants in order 0, 1, 2, 3, 0; exactly one `done` per transaction; gnt is always one-hot.
- **Contention after service:**
  - Stimulus: req[1] served; then req[1] and req[3] are both raised together.
  - Response: gnt goes to 3 first.
- **Timeout:**
  - Stimulus: the slave model holds the master so m_ready stays 0 for > TIMEOUT_CYC.
  - Response: done[owner] = 1 with err = 1 at cycle TIMEOUT_CYC; no new grant until m_ready = 1.
- **Reset mid-BUSY:**
  - Stimulus: rst = 0 during BUSY.
  - Response: gnt = 0, m_enable = 0, done = 0 asynchronously.
  - After release: the pointer is 0 and req = 0110 is granted to 1.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin arbiter sharing one I2C byte master between N_REQ requesters,
// launching one transaction per grant and aborting it if the bus hangs past TIMEOUT_CYC.
module i2c_txn_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [N_REQ-1:0]   req_rw,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               err,
  output logic [7:0]         rdata,
  output logic               m_enable,
  output logic [6:0]         m_addr,
  output logic               m_rw,
  output logic [7:0]         m_wdata,
  input  logic               m_ready,
  input  logic [7:0]         m_rdata
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef enum logic [2:0] {IDLE, LAUNCH, BUSY, FINISH, DRAIN} state_t;
  state_t           state_q;
  logic [N_REQ-1:0] gnt_q, done_q;
  logic             err_q, m_enable_q, m_rw_q;
  logic [6:0]       m_addr_q;
  logic [7:0]       m_wdata_q, rdata_q;
  logic [PW-1:0]    ptr_q, owner_q, win_d, ptr_d;
  logic [CNT_W-1:0] cnt_q;
  logic             found, timeout;
  int               idx;
  assign timeout  = cnt_q == CNT_W'(TIMEOUT_CYC - 1);
  assign ptr_d    = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign m_enable = m_enable_q;
  assign m_addr   = m_addr_q;
  assign m_rw     = m_rw_q;
  assign m_wdata  = m_wdata_q;
  // first set request at or above the pointer, wrapping back to 0
  always_comb begin
    win_d = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && req[PW'(idx)]) begin
        win_d = PW'(idx);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      m_enable_q <= 1'b0;
      m_rw_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      rdata_q    <= '0;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (m_ready && found) begin
          gnt_q      <= N_REQ'(1) << win_d;
          owner_q    <= win_d;
          m_addr_q   <= req_addr[7*win_d +: 7];
          m_rw_q     <= req_rw[win_d];
          m_wdata_q  <= req_wdata[8*win_d +: 8];
          m_enable_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= LAUNCH;
        end
        LAUNCH, BUSY: if (timeout) begin
          done_q     <= gnt_q;
          err_q      <= 1'b1;
          gnt_q      <= '0;
          m_enable_q <= 1'b0;
          ptr_q      <= ptr_d;
          state_q    <= DRAIN;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          if (state_q == LAUNCH && !m_ready) begin
            m_enable_q <= 1'b0;
            state_q    <= BUSY;
          end
          if (state_q == BUSY && m_ready) begin
            if (m_rw_q) rdata_q <= m_rdata;
            done_q  <= gnt_q;
            gnt_q   <= '0;
            state_q <= FINISH;
          end
        end
        FINISH: begin
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        DRAIN: if (m_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: table-driven transactions against a behavioural I2C master with divided enable sampling.
module tb_i2c_txn_arbiter;
  localparam int TO   = 64;
  localparam int XFER = 10;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [27:0] req_addr;
  logic [3:0]  req_rw;
  logic [31:0] req_wdata;
  logic [3:0]  gnt, done;
  logic        err, m_enable, m_rw;
  logic [7:0]  rdata, m_wdata;
  logic [6:0]  m_addr;
  logic        m_ready = 1'b1;
  logic [7:0]  m_rdata = '0;
  logic [6:0]  addr_t [4];
  logic [7:0]  wd_t [4];
  logic        rw_t [4];
  int n_chk = 0;
  int n_fail = 0;
  typedef struct { logic [3:0] req; logic [3:0] gnt; logic [7:0] rdata; logic drop; } vec_t;
  typedef struct { logic [3:0] done; logic err; logic [7:0] rdata; } exp_t;
  vec_t vecs [11];
  exp_t sb [$];
  i2c_txn_arbiter #(.N_REQ(4), .TIMEOUT_CYC(TO), .CNT_W(13)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .m_enable(m_enable), .m_addr(m_addr),
    .m_rw(m_rw), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata)
  );
  always #5 clk = ~clk;
  initial begin
    addr_t = '{7'h50, 7'h21, 7'h68, 7'h3F};
    wd_t   = '{8'hA5, 8'h11, 8'h5A, 8'hC3};
    rw_t   = '{1'b0, 1'b1, 1'b1, 1'b0};
  end
  assign req_addr  = {addr_t[3], addr_t[2], addr_t[1], addr_t[0]};
  assign req_wdata = {wd_t[3], wd_t[2], wd_t[1], wd_t[0]};
  assign req_rw    = {rw_t[3], rw_t[2], rw_t[1], rw_t[0]};
  function automatic logic [7:0] slave_rd(input logic [6:0] a);
    return {1'b0, a} ^ 8'h54;
  endfunction
  // master: samples enable every 4th clock, then busy for XFER cycles unless hung
  logic [1:0] div = '0;
  int         busy = 0;
  logic       hang = 1'b0;
  logic       cap_rw = 1'b0;
  logic [6:0] cap_addr = '0;
  always @(posedge clk) begin
    div <= div + 1'b1;
    if (m_ready) begin
      if (div == 2'd0 && m_enable) begin
        m_ready  <= 1'b0;
        busy     <= XFER;
        cap_rw   <= m_rw;
        cap_addr <= m_addr;
      end
    end else if (!hang) begin
      if (busy == 0) begin
        m_ready <= 1'b1;
        m_rdata <= cap_rw ? slave_rd(cap_addr) : 8'hEE;
      end else busy <= busy - 1;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (rst) begin
    chk("gnt_onehot", 32'($onehot0(gnt)), 1);
    chk("done_onehot", 32'($onehot0(done)), 1);
  end
  task automatic wait_grant(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 200);
  endtask
  task automatic run_vec(input logic [3:0] r, input logic [3:0] eg, input logic [7:0] erd, input logic drop);
    int n, o;
    logic r1, r2;
    exp_t e;
    req = r;
    wait_grant(n);
    chk("grant", gnt, eg);
    if (gnt == '0) return;
    o = 0;
    for (int i = 0; i < 4; i++) if (eg[i]) o = i;
    chk("launch_enable", m_enable, 1);
    chk("launch_addr", m_addr, addr_t[o]);
    chk("launch_rw", m_rw, rw_t[o]);
    chk("launch_wdata", m_wdata, wd_t[o]);
    sb.push_back('{eg, 1'b0, erd});
    if (drop) req = '0;
    r1 = m_ready;
    r2 = m_ready;
    n = 0;
    do begin r2 = r1; r1 = m_ready; @(negedge clk); n++; end while (done == '0 && n < 400);
    e = sb.pop_front();
    chk("done", done, e.done);
    chk("err", err, e.err);
    chk("rdata", rdata, e.rdata);
    chk("ready_to_done", {r2, r1}, 2'b01);
    chk("hold_addr", m_addr, addr_t[o]);
    chk("hold_wdata", m_wdata, wd_t[o]);
    chk("gnt_at_done", gnt, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_gap_gnt", gnt, 0);
    chk("rdata_held", rdata, e.rdata);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic [3:0] seen;
    exp_t e;
    vecs[0]  = '{4'b0001, 4'b0001, 8'h00, 1'b0};
    vecs[1]  = '{4'b0100, 4'b0100, 8'h3C, 1'b1};
    vecs[2]  = '{4'b1000, 4'b1000, 8'h3C, 1'b1};
    vecs[3]  = '{4'b1111, 4'b0001, 8'h3C, 1'b0};
    vecs[4]  = '{4'b1111, 4'b0010, 8'h75, 1'b0};
    vecs[5]  = '{4'b1111, 4'b0100, 8'h3C, 1'b0};
    vecs[6]  = '{4'b1111, 4'b1000, 8'h3C, 1'b0};
    vecs[7]  = '{4'b1111, 4'b0001, 8'h3C, 1'b0};
    vecs[8]  = '{4'b0010, 4'b0010, 8'h75, 1'b0};
    vecs[9]  = '{4'b1010, 4'b1000, 8'h75, 1'b0};
    vecs[10] = '{4'b1010, 4'b0010, 8'h75, 1'b0};
    #1 rst = 1'b0;
    req = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_enable", m_enable, 0);
    chk("rst_rw", m_rw, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_wdata", m_wdata, 0);
    chk("rst_rdata", rdata, 0);
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 11; i++) run_vec(vecs[i].req, vecs[i].gnt, vecs[i].rdata, vecs[i].drop);
    // hung bus: pointer sits at 2, only requester 0 asks
    hang = 1'b1;
    req = 4'b0001;
    wait_grant(n);
    chk("to_grant", gnt, 4'b0001);
    sb.push_back('{4'b0001, 1'b1, 8'h75});
    n = 0;
    do begin @(negedge clk); n++; end while (done == '0 && n < 4 * TO);
    e = sb.pop_front();
    chk("to_latency", n, TO);
    chk("to_done", done, e.done);
    chk("to_err", err, e.err);
    chk("to_rdata", rdata, e.rdata);
    chk("to_enable", m_enable, 0);
    chk("to_gnt", gnt, 0);
    @(negedge clk);
    chk("to_err_pulse", {done, err}, 0);
    req = 4'b0011;
    seen = '0;
    repeat (20) begin @(negedge clk); seen = seen | gnt; end
    chk("drain_nogrant", seen, 0);
    hang = 1'b0;
    run_vec(4'b0011, 4'b0010, 8'h75, 1'b0);
    // reset while busy; pointer is 2 here, so without reset 0110 would go to 2
    req = 4'b0100;
    wait_grant(n);
    chk("rb_grant", gnt, 4'b0100);
    n = 0;
    while (m_ready && n < 50) begin @(negedge clk); n++; end
    chk("rb_busy", m_ready, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rb_gnt", gnt, 0);
    chk("rb_enable", m_enable, 0);
    chk("rb_done", done, 0);
    chk("rb_addr", m_addr, 0);
    chk("rb_rdata", rdata, 0);
    req = 4'b0110;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_vec(4'b0110, 4'b0010, 8'h75, 1'b0);
    req = '0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
